bnn_param_loader: RTL and testbench

//  Sequences serial configuration of the neuron parameter daisy chain (setup / param_in -> param_out).

---
 rtl/bnn_param_loader_if.sv | 25 ++
 rtl/bnn_param_loader.sv | 143 ++++++++++++++
 tb/tb_bnn_param_loader.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/bnn_param_loader_if.sv
// Byte-stream, daisy-chain and status bundle for bnn_param_loader.
// slave = loader side, master = chip I/O / neuron array side.
interface bnn_param_loader_if;
  logic       start;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       setup;
  logic       param_out;
  logic       chain_in;
  logic       busy;
  logic       done;
  logic [7:0] rb_data;
  logic       rb_valid;

  modport slave (
    input  start, in_data, in_valid, chain_in,
    output in_ready, setup, param_out, busy, done, rb_data, rb_valid
  );

  modport master (
    output start, in_data, in_valid, chain_in,
    input  in_ready, setup, param_out, busy, done, rb_data, rb_valid
  );
endinterface

// File: rtl/bnn_param_loader.sv
// Serial loader for the neuron parameter daisy chain: bytes in, CHAIN_BITS bits shifted out MSB first.
// Optional chain readback enabled by defining BNN_PARAM_LOADER_READBACK_EN.
module bnn_param_loader #(
  parameter int unsigned NEURONS   = 4,
  parameter int unsigned INPUTS    = 8,
  parameter int unsigned BIAS_BITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  bnn_param_loader_if.slave   bus
);

  localparam int unsigned CHAIN_BITS = NEURONS * (INPUTS + BIAS_BITS);
  localparam int unsigned CNT_W      = $clog2(CHAIN_BITS + 1);
  localparam logic [CNT_W-1:0] ChainLen = CNT_W'(CHAIN_BITS);
  localparam logic [CNT_W-1:0] LastBit  = CNT_W'(CHAIN_BITS - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  state_e           r_state;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [7:0]       r_shreg;
  logic [3:0]       r_byte_left;
  logic             r_in_ready;
  logic             r_setup;
  logic             r_param_out;
  logic             r_busy;
  logic             r_done;

  logic [CNT_W-1:0] w_remaining;
  logic [3:0]       w_byte_bits;
  logic             w_accept;

  // Final byte may be partial: only its top (CHAIN_BITS - bit_cnt) bits are shifted.
  always_comb begin
    w_remaining = ChainLen - r_bit_cnt;
    w_byte_bits = (w_remaining >= CNT_W'(8)) ? 4'd8 : w_remaining[3:0];
    w_accept    = bus.in_valid & r_in_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_bit_cnt   <= '0;
      r_shreg     <= '0;
      r_byte_left <= '0;
      r_in_ready  <= 1'b0;
      r_setup     <= 1'b0;
      r_param_out <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_state    <= StLoad;
            r_busy     <= 1'b1;
            r_bit_cnt  <= '0;
            r_in_ready <= 1'b1;
          end
        end
        StLoad: begin
          if (w_accept) begin
            r_shreg     <= bus.in_data;
            r_setup     <= 1'b1;
            r_param_out <= bus.in_data[7];
            r_in_ready  <= 1'b0;
            r_byte_left <= w_byte_bits;
            r_state     <= StShift;
          end
        end
        StShift: begin
          // The chain captures param_out on this edge; present the next bit alongside it.
          r_shreg     <= {r_shreg[6:0], 1'b0};
          r_param_out <= r_shreg[6];
          r_bit_cnt   <= r_bit_cnt + 1'b1;
          r_byte_left <= r_byte_left - 1'b1;
          if (r_byte_left == 4'd1) begin
            r_setup <= 1'b0;
            if (r_bit_cnt == LastBit) begin
              r_state <= StDone;
              r_done  <= 1'b1;
            end else begin
              r_state    <= StLoad;
              r_in_ready <= 1'b1;
            end
          end
        end
        StDone: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.setup     = r_setup;
  assign bus.param_out = r_param_out;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

`ifdef BNN_PARAM_LOADER_READBACK_EN
  logic [7:0] r_rb_sh;
  logic [7:0] r_rb_data;
  logic       r_rb_valid;
  logic [3:0] r_rb_bits;
  logic [7:0] w_rb_next;

  assign w_rb_next = {r_rb_sh[6:0], bus.chain_in};

  // Old chain contents fall out of chain_in in the order they were originally loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rb_sh    <= '0;
      r_rb_data  <= '0;
      r_rb_valid <= 1'b0;
      r_rb_bits  <= '0;
    end else begin
      r_rb_valid <= 1'b0;
      if (w_accept) r_rb_bits <= w_byte_bits;
      if (r_setup) begin
        r_rb_sh <= w_rb_next;
        if (r_byte_left == 4'd1) begin
          r_rb_valid <= 1'b1;
          r_rb_data  <= w_rb_next << (4'd8 - r_rb_bits);
        end
      end
    end
  end

  assign bus.rb_data  = r_rb_data;
  assign bus.rb_valid = r_rb_valid;
`else
  logic w_unused_chain_in;
  assign w_unused_chain_in = bus.chain_in;
  assign bus.rb_data  = '0;
  assign bus.rb_valid = 1'b0;
`endif

endmodule

// File: tb/tb_bnn_param_loader.sv
// Directed bench for bnn_param_loader with a 44-bit neuron chain model on param_out/chain_in.
module tb_bnn_param_loader;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  bnn_param_loader_if bus ();

  bnn_param_loader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Neuron chain model: first bit shifted ends at bit 43 (last neuron bias MSB).
  logic [43:0] chain = '0;
  always @(posedge clk) if (bus.setup) chain <= {chain[42:0], bus.param_out};
  assign bus.chain_in = chain[43];

  int setup_total = 0;
  int done_total  = 0;
  int rb_total    = 0;
  logic [7:0] rb_q[$];
  always @(posedge clk) begin
    if (bus.setup) setup_total++;
    if (bus.done) done_total++;
    if (bus.rb_valid) begin
      rb_total++;
      rb_q.push_back(bus.rb_data);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [47:0] bytes;
    int          gap;
    bit          mid_start;
    logic [43:0] exp_chain;
  } vec_t;

  vec_t vecs[4];

  task automatic check_reset_outputs(input string tag);
    check({tag, " setup"},     64'(bus.setup),     64'd0);
    check({tag, " param_out"}, 64'(bus.param_out), 64'd0);
    check({tag, " in_ready"},  64'(bus.in_ready),  64'd0);
    check({tag, " busy"},      64'(bus.busy),      64'd0);
    check({tag, " done"},      64'(bus.done),      64'd0);
    check({tag, " rb_valid"},  64'(bus.rb_valid),  64'd0);
  endtask

  // Waits (bounded) for in_ready at a negedge; returns 1 on timeout.
  task automatic wait_ready(output bit to);
    int t = 0;
    while (!bus.in_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    to = (t >= 40);
  endtask

  task automatic run_load(input string tag, input logic [47:0] bytes, input int gap,
                          input bit mid_start, input logic [43:0] exp_chain);
    int base_setup = setup_total;
    int base_done  = done_total;
    int gap_bad    = 0;
    int t          = 0;
    bit to         = 0;
    bit to_any     = 0;
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wait_ready(to);
      to_any |= to;
      repeat (gap) begin
        if (bus.setup) gap_bad++;
        @(negedge clk);
      end
      bus.in_data  = bytes[47-8*i -: 8];
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      if (mid_start && i == 2) begin
        @(negedge clk);
        check({tag, " setup during mid start"}, 64'(bus.setup), 64'd1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
      end
    end
    while (done_total == base_done && t < 60) begin
      @(negedge clk);
      t++;
    end
    to_any |= (t >= 60);
    repeat (3) @(negedge clk);
    check({tag, " timeout"},    64'(to_any),                  64'd0);
    check({tag, " setup bits"}, 64'(setup_total - base_setup), 64'd44);
    check({tag, " done pulses"}, 64'(done_total - base_done),  64'd1);
    check({tag, " gap setup"},  64'(gap_bad),                  64'd0);
    check({tag, " busy idle"},  64'(bus.busy),                 64'd0);
    check({tag, " chain"},      64'(chain),                    64'(exp_chain));
  endtask

  initial begin
    int base;
    int t;
    bit to;
    bus.start    = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;

    vecs[0] = '{bytes: 48'hA53CF00F8193, gap: 0, mid_start: 1'b0, exp_chain: 44'hA53CF00F819};
    vecs[1] = '{bytes: 48'hA53CF00F8193, gap: 5, mid_start: 1'b0, exp_chain: 44'hA53CF00F819};
    vecs[2] = '{bytes: 48'hFF00FF00FFF0, gap: 0, mid_start: 1'b0, exp_chain: 44'hFF00FF00FFF};
    vecs[3] = '{bytes: 48'h123456789ABC, gap: 2, mid_start: 1'b1, exp_chain: 44'h123456789AB};

    #2 rst_n = 1'b0;
    #1 check_reset_outputs("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle in_ready", 64'(bus.in_ready), 64'd0);

    for (int v = 0; v < 4; v++) begin
      run_load($sformatf("vec%0d", v), vecs[v].bytes, vecs[v].gap, vecs[v].mid_start,
               vecs[v].exp_chain);
      if (v == 0) check("last neuron bias", 64'(chain[43:41]), 64'b101);
    end

    // Reset in the middle of a load, after 20 bits have gone out.
    base = setup_total;
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_ready(to);
      bus.in_data  = 8'hC3;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    t = 0;
    while ((setup_total - base) < 20 && t < 60) begin
      @(negedge clk);
      t++;
    end
    check("midreset reached bit 20", 64'(setup_total - base), 64'd20);
    check("midreset busy before", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_load("after reset", vecs[0].bytes, 0, 1'b0, vecs[0].exp_chain);

`ifdef BNN_PARAM_LOADER_READBACK_EN
    begin
      int rb_base;
      logic [7:0] exp_rb;
      run_load("rb p1", 48'h5A1E7F80C3D6, 0, 1'b0, 44'h5A1E7F80C3D);
      rb_base = rb_total;
      run_load("rb p2", vecs[2].bytes, 0, 1'b0, vecs[2].exp_chain);
      check("rb count", 64'(rb_total - rb_base), 64'd6);
      for (int k = 0; k < 6; k++) begin
        logic [47:0] p1 = 48'h5A1E7F80C3D6;
        exp_rb = p1[47-8*k -: 8];
        if (k == 5) exp_rb = exp_rb & 8'hF0;
        if (rb_base + k < rb_q.size())
          check($sformatf("rb byte %0d", k), 64'(rb_q[rb_base+k]), 64'(exp_rb));
        else
          check($sformatf("rb byte %0d present", k), 64'd0, 64'd1);
      end
    end
`else
    check("rb never valid", 64'(rb_total), 64'd0);
    check("rb data zero", 64'(bus.rb_data), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

endmodule
